// File: rtl/rs_dispatch.sv
// Reservation-station dispatch: holds pending operations, snoops the CDB to
// resolve waiting operands, and issues the lowest-index ready entry through a
// registered valid/ready output stage.
module rs_dispatch #(
  parameter int DEPTH  = 3,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic                         clk2,
  input  logic                         rst_n,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [3:0]                   alloc_func,
  input  logic [DATA_W-1:0]            alloc_vj,
  input  logic [DATA_W-1:0]            alloc_vk,
  input  logic [TAG_W-1:0]             alloc_qj,
  input  logic [TAG_W-1:0]             alloc_qk,
  input  logic                         alloc_rj,
  input  logic                         alloc_rk,
  input  logic [TAG_W-1:0]             alloc_rob,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  input  logic                         flush,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [3:0]                   iss_func,
  output logic [DATA_W-1:0]            iss_vj,
  output logic [DATA_W-1:0]            iss_vk,
  output logic [TAG_W-1:0]             iss_rob,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  r_rj;
  logic [DEPTH-1:0]  r_rk;
  logic [3:0]        r_func [DEPTH];
  logic [DATA_W-1:0] r_vj   [DEPTH];
  logic [DATA_W-1:0] r_vk   [DEPTH];
  logic [TAG_W-1:0]  r_qj   [DEPTH];
  logic [TAG_W-1:0]  r_qk   [DEPTH];
  logic [TAG_W-1:0]  r_rob  [DEPTH];

  logic              r_iss_valid;
  logic [3:0]        r_iss_func;
  logic [DATA_W-1:0] r_iss_vj;
  logic [DATA_W-1:0] r_iss_vk;
  logic [TAG_W-1:0]  r_iss_rob;

  logic              w_elig_any;
  logic [IDX_W-1:0]  w_iss_idx;
  logic [3:0]        w_sel_func;
  logic [DATA_W-1:0] w_sel_vj;
  logic [DATA_W-1:0] w_sel_vk;
  logic [TAG_W-1:0]  w_sel_rob;
  logic              w_free_any;
  logic [IDX_W-1:0]  w_alloc_idx;
  logic [OCC_W-1:0]  w_occ;
  logic              w_load;
  logic              w_issue;
  logic              w_alloc;
  logic              w_fwd_j;
  logic              w_fwd_k;

  // Priority pick (lowest index wins by scanning downwards), free-slot search and popcount.
  always_comb begin
    w_elig_any  = 1'b0;
    w_iss_idx   = '0;
    w_sel_func  = '0;
    w_sel_vj    = '0;
    w_sel_vk    = '0;
    w_sel_rob   = '0;
    w_free_any  = 1'b0;
    w_alloc_idx = '0;
    w_occ       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_busy[i] && r_rj[i] && r_rk[i]) begin
        w_elig_any = 1'b1;
        w_iss_idx  = IDX_W'(i);
        w_sel_func = r_func[i];
        w_sel_vj   = r_vj[i];
        w_sel_vk   = r_vk[i];
        w_sel_rob  = r_rob[i];
      end
      if (!r_busy[i]) begin
        w_free_any  = 1'b1;
        w_alloc_idx = IDX_W'(i);
      end
      w_occ = w_occ + OCC_W'(r_busy[i]);
    end
  end

  assign w_load  = !r_iss_valid || iss_ready;
  assign w_issue = w_load && w_elig_any;
  assign w_alloc = alloc_valid && w_free_any && !flush;
  assign w_fwd_j = cdb_valid && !alloc_rj && (alloc_qj == cdb_tag);
  assign w_fwd_k = cdb_valid && !alloc_rk && (alloc_qk == cdb_tag);

  // Entry storage: flush > alloc write (with same-cycle CDB forward) > CDB snoop / issue release.
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_rj   <= '0;
      r_rk   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_func[i] <= '0;
        r_vj[i]   <= '0;
        r_vk[i]   <= '0;
        r_qj[i]   <= '0;
        r_qk[i]   <= '0;
        r_rob[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush) begin
          r_busy[i] <= 1'b0;
          r_rj[i]   <= 1'b0;
          r_rk[i]   <= 1'b0;
        end else if (w_alloc && (w_alloc_idx == IDX_W'(i))) begin
          r_busy[i] <= 1'b1;
          r_func[i] <= alloc_func;
          r_rob[i]  <= alloc_rob;
          r_qj[i]   <= alloc_qj;
          r_qk[i]   <= alloc_qk;
          r_rj[i]   <= alloc_rj || w_fwd_j;
          r_rk[i]   <= alloc_rk || w_fwd_k;
          r_vj[i]   <= w_fwd_j ? cdb_data : alloc_vj;
          r_vk[i]   <= w_fwd_k ? cdb_data : alloc_vk;
        end else if (r_busy[i]) begin
          if (cdb_valid && !r_rj[i] && (r_qj[i] == cdb_tag)) begin
            r_rj[i] <= 1'b1;
            r_vj[i] <= cdb_data;
          end
          if (cdb_valid && !r_rk[i] && (r_qk[i] == cdb_tag)) begin
            r_rk[i] <= 1'b1;
            r_vk[i] <= cdb_data;
          end
          if (w_issue && (w_iss_idx == IDX_W'(i))) begin
            r_busy[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Issue register: reloads whenever empty or being accepted, otherwise holds.
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_valid <= 1'b0;
      r_iss_func  <= '0;
      r_iss_vj    <= '0;
      r_iss_vk    <= '0;
      r_iss_rob   <= '0;
    end else if (flush) begin
      r_iss_valid <= 1'b0;
    end else if (w_load) begin
      r_iss_valid <= w_elig_any;
      if (w_elig_any) begin
        r_iss_func <= w_sel_func;
        r_iss_vj   <= w_sel_vj;
        r_iss_vk   <= w_sel_vk;
        r_iss_rob  <= w_sel_rob;
      end
    end
  end

  assign alloc_ready = w_free_any;
  assign occupancy   = w_occ;
  assign iss_valid   = r_iss_valid;
  assign iss_func    = r_iss_func;
  assign iss_vj      = r_iss_vj;
  assign iss_vk      = r_iss_vk;
  assign iss_rob     = r_iss_rob;

endmodule

// File: tb/tb_rs_dispatch.sv
// Directed bench for rs_dispatch: reset, ready issue, CDB wakeup, alloc-time
// forwarding, backpressure with a full station, flush and async reset.
module tb_rs_dispatch;

  logic        clk2;
  logic        rst_n;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [3:0]  alloc_func;
  logic [15:0] alloc_vj;
  logic [15:0] alloc_vk;
  logic [2:0]  alloc_qj;
  logic [2:0]  alloc_qk;
  logic        alloc_rj;
  logic        alloc_rk;
  logic [2:0]  alloc_rob;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        flush;
  logic        iss_valid;
  logic        iss_ready;
  logic [3:0]  iss_func;
  logic [15:0] iss_vj;
  logic [15:0] iss_vk;
  logic [2:0]  iss_rob;
  logic [1:0]  occupancy;

  int n_total;
  int n_bad;

  rs_dispatch #(.DEPTH(3), .DATA_W(16), .TAG_W(3)) dut (
    .clk2(clk2), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_func(alloc_func),
    .alloc_vj(alloc_vj), .alloc_vk(alloc_vk), .alloc_qj(alloc_qj), .alloc_qk(alloc_qk),
    .alloc_rj(alloc_rj), .alloc_rk(alloc_rk), .alloc_rob(alloc_rob),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_func(iss_func),
    .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_rob(iss_rob), .occupancy(occupancy)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic set_alloc(input logic [3:0] f, input logic [15:0] vj, input logic [15:0] vk,
                           input logic [2:0] qj, input logic [2:0] qk,
                           input logic rj, input logic rk, input logic [2:0] rob);
    alloc_valid = 1'b1;
    alloc_func  = f;
    alloc_vj    = vj;
    alloc_vk    = vk;
    alloc_qj    = qj;
    alloc_qk    = qk;
    alloc_rj    = rj;
    alloc_rk    = rk;
    alloc_rob   = rob;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n = 1'b0;
    alloc_valid = 0; alloc_func = 0; alloc_vj = 0; alloc_vk = 0;
    alloc_qj = 0; alloc_qk = 0; alloc_rj = 0; alloc_rk = 0; alloc_rob = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0; flush = 0; iss_ready = 0;

    // Reset state
    #1;
    chk("rst_iss_valid", 32'(iss_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst_iss_rob", 32'(iss_rob), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Ready alloc: minimum latency one edge
    iss_ready = 1'b1;
    set_alloc(4'h0, 16'd5, 16'd7, 3'd0, 3'd0, 1'b1, 1'b1, 3'd2);
    tick();
    alloc_valid = 1'b0;
    chk("rdy_occ_after_alloc", 32'(occupancy), 32'd1);
    chk("rdy_not_early", 32'(iss_valid), 32'd0);
    tick();
    chk("rdy_iss_valid", 32'(iss_valid), 32'd1);
    chk("rdy_iss_vj", 32'(iss_vj), 32'd5);
    chk("rdy_iss_vk", 32'(iss_vk), 32'd7);
    chk("rdy_iss_rob", 32'(iss_rob), 32'd2);
    chk("rdy_iss_func", 32'(iss_func), 32'd0);
    chk("rdy_occ", 32'(occupancy), 32'd0);
    tick();
    chk("rdy_drain", 32'(iss_valid), 32'd0);

    // CDB wakeup, including a non-matching tag
    set_alloc(4'h1, 16'd0, 16'd3, 3'd4, 3'd0, 1'b0, 1'b1, 3'd1);
    tick();
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 16'hAAAA;
    tick();
    chk("cdb_wrong_tag_valid", 32'(iss_valid), 32'd0);
    chk("cdb_wrong_tag_occ", 32'(occupancy), 32'd1);
    cdb_tag = 3'd4; cdb_data = 16'd9;
    tick();
    chk("cdb_not_same_edge", 32'(iss_valid), 32'd0);
    cdb_valid = 1'b0;
    tick();
    chk("cdb_iss_valid", 32'(iss_valid), 32'd1);
    chk("cdb_iss_vj", 32'(iss_vj), 32'd9);
    chk("cdb_iss_vk", 32'(iss_vk), 32'd3);
    chk("cdb_iss_rob", 32'(iss_rob), 32'd1);
    chk("cdb_iss_func", 32'(iss_func), 32'd1);
    tick();
    chk("cdb_drain", 32'(iss_valid), 32'd0);

    // Alloc-time forwarding from the CDB
    set_alloc(4'h2, 16'd0, 16'd1, 3'd6, 3'd0, 1'b0, 1'b1, 3'd3);
    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 16'h1234;
    tick();
    alloc_valid = 1'b0;
    cdb_valid = 1'b0;
    tick();
    chk("fwd_iss_valid", 32'(iss_valid), 32'd1);
    chk("fwd_iss_vj", 32'(iss_vj), 32'h1234);
    chk("fwd_iss_rob", 32'(iss_rob), 32'd3);
    tick();

    // Backpressure and full station
    iss_ready = 1'b0;
    set_alloc(4'h3, 16'h0010, 16'h0100, 3'd0, 3'd0, 1'b1, 1'b1, 3'd0);
    tick();
    alloc_valid = 1'b0;
    tick();
    chk("bp_first_issued", 32'(iss_valid), 32'd1);
    chk("bp_first_rob", 32'(iss_rob), 32'd0);
    for (int r = 1; r <= 3; r++) begin
      set_alloc(4'h3, 16'(16 * (r + 1)), 16'(256 * (r + 1)), 3'd0, 3'd0, 1'b1, 1'b1, 3'(r));
      tick();
    end
    chk("bp_full_occ", 32'(occupancy), 32'd3);
    chk("bp_full_alloc_ready", 32'(alloc_ready), 32'd0);
    set_alloc(4'h3, 16'hFFFF, 16'hFFFF, 3'd0, 3'd0, 1'b1, 1'b1, 3'd4);
    tick();
    alloc_valid = 1'b0;
    chk("bp_5th_ignored_occ", 32'(occupancy), 32'd3);
    chk("bp_held_rob", 32'(iss_rob), 32'd0);
    chk("bp_held_vj", 32'(iss_vj), 32'h0010);
    iss_ready = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      tick();
      chk("bp_order_valid", 32'(iss_valid), 32'd1);
      chk("bp_order_rob", 32'(iss_rob), 32'(r));
      chk("bp_order_vj", 32'(iss_vj), 32'(16 * (r + 1)));
      chk("bp_order_occ", 32'(occupancy), 32'(3 - r));
    end
    tick();
    chk("bp_no_5th", 32'(iss_valid), 32'd0);

    // Flush with two busy entries and a held issue register
    iss_ready = 1'b0;
    set_alloc(4'h4, 16'd1, 16'd1, 3'd0, 3'd0, 1'b1, 1'b1, 3'd5);
    tick();
    alloc_valid = 1'b0;
    tick();
    set_alloc(4'h4, 16'd2, 16'd2, 3'd0, 3'd0, 1'b1, 1'b1, 3'd6);
    tick();
    set_alloc(4'h4, 16'd3, 16'd3, 3'd2, 3'd0, 1'b0, 1'b1, 3'd7);
    tick();
    chk("fl_pre_occ", 32'(occupancy), 32'd2);
    chk("fl_pre_valid", 32'(iss_valid), 32'd1);
    set_alloc(4'h5, 16'd9, 16'd9, 3'd0, 3'd0, 1'b1, 1'b1, 3'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    alloc_valid = 1'b0;
    chk("fl_occ", 32'(occupancy), 32'd0);
    chk("fl_iss_valid", 32'(iss_valid), 32'd0);
    chk("fl_alloc_ready", 32'(alloc_ready), 32'd1);
    iss_ready = 1'b1;
    tick();
    chk("fl_alloc_dropped", 32'(iss_valid), 32'd0);
    chk("fl_occ_after", 32'(occupancy), 32'd0);

    // Async reset mid-handshake
    iss_ready = 1'b0;
    set_alloc(4'h6, 16'd4, 16'd4, 3'd0, 3'd0, 1'b1, 1'b1, 3'd4);
    tick();
    set_alloc(4'h6, 16'd5, 16'd5, 3'd0, 3'd0, 1'b1, 1'b1, 3'd5);
    tick();
    alloc_valid = 1'b0;
    chk("ar_pre_valid", 32'(iss_valid), 32'd1);
    chk("ar_pre_occ", 32'(occupancy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_iss_valid", 32'(iss_valid), 32'd0);
    chk("ar_occ", 32'(occupancy), 32'd0);
    chk("ar_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("ar_iss_rob", 32'(iss_rob), 32'd0);
    tick();
    rst_n = 1'b1;
    iss_ready = 1'b1;
    tick();
    chk("ar_discarded", 32'(iss_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rs_dispatch.md
# rs_dispatch

Dispatch side of a Tomasulo reservation station: holds up to DEPTH pending operations, snoops the common data bus (CDB) to resolve waiting operands, and issues the lowest-index fully-ready entry to its functional unit over a valid/ready handshake. Entries are written by the decode/issue stage through the alloc port. The block sits between the ROB/register-status lookup and one functional unit (adder or multiplier class).

## Interface
Parameters:
- DEPTH, 3, number of RS entries
- DATA_W, 16, operand value width
- TAG_W, 3, ROB tag width

Ports:
- clk2  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- alloc_valid  in  1  new operation offered
- alloc_ready  out  1  at least one free entry (registered state)
- alloc_func  in  4  opcode
- alloc_vj / alloc_vk  in  DATA_W  operand value, meaningful when matching r bit is 1
- alloc_qj / alloc_qk  in  TAG_W  producing ROB tag, meaningful when r bit is 0
- alloc_rj / alloc_rk  in  1  operand already available
- alloc_rob  in  TAG_W  destination ROB tag
- cdb_valid  in  1  result broadcast this cycle
- cdb_tag  in  TAG_W  broadcasting ROB tag
- cdb_data  in  DATA_W  broadcast value
- flush  in  1  synchronous clear of all entries and output
- iss_valid  out  1  issue register holds an operation
- iss_ready  in  1  functional unit accepts
- iss_func  out  4; iss_vj, iss_vk  out  DATA_W; iss_rob  out  TAG_W  issued operation
- occupancy  out  $clog2(DEPTH+1)  busy entries, excluding the issue register

## Operation
- Entry fields: busy, func, vj, qj, rj, vk, qk, rk, rob.
- Allocation: on alloc_valid && alloc_ready, write lowest-index free entry; busy=1.
- Alloc-time forwarding: if cdb_valid and an operand has r=0 with q==cdb_tag in the same cycle, the entry stores v=cdb_data, r=1.
- CDB snoop: each busy entry with r=0 and q==cdb_tag under cdb_valid sets v=cdb_data, r=1. Both operands may match in one cycle.
- Eligibility: busy && rj && rk, from registered flags. An operand resolved this cycle becomes eligible next cycle.
- Selection: lowest-index eligible entry.
- Issue register load condition: !iss_valid || iss_ready. When it holds and an entry is eligible: copy the entry to iss_*, set iss_valid=1, clear that entry's busy. When it holds and nothing is eligible: iss_valid=0.
- Output is held stable while iss_valid && !iss_ready.
- Sustained throughput: one issue per cycle.
- Freed entries become allocatable the next cycle. alloc_ready is never combinationally dependent on iss_ready.
- Same-entry free and alloc in one cycle cannot occur; the alloc target is chosen from current busy bits.
- flush: has priority over alloc, CDB and issue. Clears every busy, r bit and iss_valid next edge. alloc in the flush cycle is dropped.
- occupancy = popcount(busy).

## Timing
- Reset (async, rst_n=0): every busy=0, all r bits 0, iss_valid=0, iss_func/iss_vj/iss_vk/iss_rob=0, occupancy=0, alloc_ready=1.
- Minimum latency: alloc with both operands ready at edge N, iss_valid at edge N+1.
- Operand waiting, CDB at edge M: iss_valid no earlier than edge M+1.
- Full (occupancy==DEPTH): alloc_ready=0 and alloc_valid is ignored.
- Full with issue register stalled: no entry leaves and nothing is lost.
- Reset asserted mid-handshake: iss_valid drops immediately and the in-flight operation is discarded.

## Test plan
- Reset: assert rst_n=0 asynchronously with iss_valid=1 -> iss_valid=0, occupancy=0 and alloc_ready=1 before the next edge.
- Ready alloc: alloc func=0000, vj=5, vk=7, rj=rk=1, rob=2 with iss_ready=1 -> next cycle iss_valid=1, iss_vj=5, iss_vk=7, iss_rob=2, occupancy=0.
- CDB wakeup: alloc rj=0, qj=4, rk=1, vk=3; two cycles later cdb_valid, tag=4, data=9 -> iss_valid one cycle after the CDB, iss_vj=9. A non-matching tag=5 must not wake the entry.
- Same-cycle forward: alloc qj=6, rj=0, rk=1 while cdb tag=6, data=0x1234 -> issues next cycle with iss_vj=0x1234.
- Backpressure/full: iss_ready=0; alloc 4 ready ops, rob=0..3 -> the first goes to the issue register, 3 entries fill, alloc_ready=0 and a 5th alloc is ignored. Release iss_ready -> issue order rob 0,1,2,3 on consecutive cycles.
- Flush: with 2 busy entries and iss_valid=1, pulse flush together with alloc_valid -> next cycle occupancy=0, iss_valid=0, and the concurrent alloc is not stored.
